// File: rtl/regfile_scoreboard.sv
// Multi-port register file with a hardwired-zero register, same-cycle write bypass,
// and a per-register busy scoreboard for hazard detection.
module regfile_scoreboard #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ZERO_REG = DEPTH - 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*WIDTH-1:0]  rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    mark_en,
    input  logic [ADDR_W-1:0]       mark_addr,
    input  logic                    flush
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_ok;
    logic             mark_ok;

    // True for an in-range register that is not the hardwired zero.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH) && (32'(a) != ZERO_REG);
    endfunction

    assign wr_ok   = wr_en && addr_ok(wr_addr);
    assign mark_ok = mark_en && addr_ok(mark_addr);

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            if (wr_ok && wr_addr == ADDR_W'(r)) begin
                mem_d[r] = wr_data;
            end
            // A new producer outranks the one retiring in the same cycle.
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (mark_ok && mark_addr == ADDR_W'(r)) begin
                busy_d[r] = 1'b1;
            end else if (wr_ok && wr_addr == ADDR_W'(r)) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [WIDTH-1:0]  stored;
        logic              sbusy;
        logic              hit;
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        stored  = '0;
        sbusy   = 1'b0;
        hit     = 1'b0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            ra     = rd_addr[k*ADDR_W +: ADDR_W];
            stored = '0;
            sbusy  = 1'b0;
            for (int unsigned r = 0; r < DEPTH; r++) begin
                if (ra == ADDR_W'(r)) begin
                    stored = mem_q[r];
                    sbusy  = busy_q[r];
                end
            end
            hit = wr_en && (wr_addr == ra);
            // Outputs are forced quiet while reset is held, even against a live write.
            if (reset_n && addr_ok(ra)) begin
                rd_data[k*WIDTH +: WIDTH] = hit ? wr_data : stored;
                rd_busy[k]                = sbusy && !hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a default instance and a small
// (32-bit, 24-deep, 3-port, zero at index 0) instance, checked through an expectation queue.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Default instance: WIDTH 64, DEPTH 32, NREAD 2, ZERO_REG 31.
    logic        wr_en0 = 1'b0;
    logic [4:0]  wr_addr0 = '0;
    logic [63:0] wr_data0 = '0;
    logic [9:0]  rd_addr0 = '0;
    logic [127:0] rd_data0;
    logic [1:0]  rd_busy0;
    logic        mark_en0 = 1'b0;
    logic [4:0]  mark_addr0 = '0;
    logic        flush0 = 1'b0;

    // Swept instance: WIDTH 32, DEPTH 24, NREAD 3, ZERO_REG 0.
    logic        wr_en1 = 1'b0;
    logic [4:0]  wr_addr1 = '0;
    logic [31:0] wr_data1 = '0;
    logic [14:0] rd_addr1 = '0;
    logic [95:0] rd_data1;
    logic [2:0]  rd_busy1;
    logic        mark_en1 = 1'b0;
    logic [4:0]  mark_addr1 = '0;
    logic        flush1 = 1'b0;

    regfile_scoreboard u_dut0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en0),
        .wr_addr   (wr_addr0),
        .wr_data   (wr_data0),
        .rd_addr   (rd_addr0),
        .rd_data   (rd_data0),
        .rd_busy   (rd_busy0),
        .mark_en   (mark_en0),
        .mark_addr (mark_addr0),
        .flush     (flush0)
    );

    regfile_scoreboard #(
        .WIDTH    (32),
        .DEPTH    (24),
        .NREAD    (3),
        .ZERO_REG (0)
    ) u_dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en1),
        .wr_addr   (wr_addr1),
        .wr_data   (wr_data1),
        .rd_addr   (rd_addr1),
        .rd_data   (rd_data1),
        .rd_busy   (rd_busy1),
        .mark_en   (mark_en1),
        .mark_addr (mark_addr1),
        .flush     (flush1)
    );

    typedef struct {
        string       tag;
        int          dut;
        int          port;
        bit          is_busy;
        logic [63:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_val(input string tag, input int dut, input int port,
                              input bit is_busy, input logic [63:0] val);
        exp_t e;
        e.tag     = tag;
        e.dut     = dut;
        e.port    = port;
        e.is_busy = is_busy;
        e.val     = val;
        q.push_back(e);
    endtask

    function automatic logic [63:0] observe(input exp_t e);
        if (e.dut == 0) begin
            if (e.is_busy) return {63'b0, rd_busy0[e.port]};
            return rd_data0[e.port*64 +: 64];
        end
        if (e.is_busy) return {63'b0, rd_busy1[e.port]};
        return {32'b0, rd_data1[e.port*32 +: 32]};
    endfunction

    task automatic check_all();
        exp_t        e;
        logic [63:0] obs;
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = observe(e);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Compare at the falling edge, then clear strobes just after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
        wr_en0 = 1'b0; mark_en0 = 1'b0; flush0 = 1'b0;
        wr_en1 = 1'b0; mark_en1 = 1'b0; flush1 = 1'b0;
    endtask

    initial begin
        // Held in reset: even a live bypass write must read as zero.
        wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 64'hDEAD; rd_addr0 = {5'd3, 5'd3};
        expect_val("rst_data", 0, 0, 1'b0, 64'h0);
        expect_val("rst_busy", 0, 1, 1'b1, 64'h0);
        cycle();
        reset_n = 1'b1;

        wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 64'hDEAD; rd_addr0 = {5'd3, 5'd3};
        expect_val("r3_bypass", 0, 0, 1'b0, 64'hDEAD);
        cycle();
        expect_val("r3_stored", 0, 1, 1'b0, 64'hDEAD);
        cycle();

        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        expect_val("r3_after_async_rst", 0, 0, 1'b0, 64'h0);
        cycle();

        wr_en0 = 1'b1; wr_addr0 = 5'd31; wr_data0 = 64'h1234; rd_addr0 = {5'd31, 5'd31};
        expect_val("zero_bypass", 0, 0, 1'b0, 64'h0);
        cycle();
        expect_val("zero_stored", 0, 1, 1'b0, 64'h0);
        cycle();

        wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 64'h11;
        cycle();
        wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 64'h22; rd_addr0 = {5'd5, 5'd5};
        expect_val("r5_byp_p0", 0, 0, 1'b0, 64'h22);
        expect_val("r5_byp_p1", 0, 1, 1'b0, 64'h22);
        cycle();
        expect_val("r5_st_p0", 0, 0, 1'b0, 64'h22);
        expect_val("r5_st_p1", 0, 1, 1'b0, 64'h22);
        cycle();

        mark_en0 = 1'b1; mark_addr0 = 5'd7; rd_addr0 = {5'd7, 5'd7};
        expect_val("r7_busy_same_cycle", 0, 0, 1'b1, 64'h0);
        cycle();
        expect_val("r7_busy_next", 0, 0, 1'b1, 64'h1);
        cycle();
        wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 64'h7;
        expect_val("r7_busy_wr", 0, 0, 1'b1, 64'h0);
        expect_val("r7_data_wr", 0, 1, 1'b0, 64'h7);
        cycle();
        expect_val("r7_busy_after", 0, 1, 1'b1, 64'h0);
        cycle();

        mark_en0 = 1'b1; mark_addr0 = 5'd9; wr_en0 = 1'b1; wr_addr0 = 5'd9;
        wr_data0 = 64'h99; rd_addr0 = {5'd9, 5'd9};
        cycle();
        expect_val("r9_busy_markwr", 0, 0, 1'b1, 64'h1);
        expect_val("r9_data_markwr", 0, 1, 1'b0, 64'h99);
        cycle();
        mark_en0 = 1'b1; mark_addr0 = 5'd9; flush0 = 1'b1;
        cycle();
        expect_val("r9_busy_markflush", 0, 0, 1'b1, 64'h0);
        cycle();

        wr_en0 = 1'b1; wr_addr0 = 5'd1; wr_data0 = 64'hA1; cycle();
        wr_en0 = 1'b1; wr_addr0 = 5'd2; wr_data0 = 64'hA2; cycle();
        wr_en0 = 1'b1; wr_addr0 = 5'd4; wr_data0 = 64'hA4; cycle();
        mark_en0 = 1'b1; mark_addr0 = 5'd1; cycle();
        mark_en0 = 1'b1; mark_addr0 = 5'd2; cycle();
        mark_en0 = 1'b1; mark_addr0 = 5'd4; rd_addr0 = {5'd2, 5'd1};
        expect_val("r1_busy", 0, 0, 1'b1, 64'h1);
        expect_val("r2_busy", 0, 1, 1'b1, 64'h1);
        cycle();
        rd_addr0 = {5'd4, 5'd4}; flush0 = 1'b1;
        expect_val("r4_busy", 0, 0, 1'b1, 64'h1);
        cycle();
        rd_addr0 = {5'd2, 5'd1};
        expect_val("r1_flushed", 0, 0, 1'b1, 64'h0);
        expect_val("r2_flushed", 0, 1, 1'b1, 64'h0);
        expect_val("r1_kept", 0, 0, 1'b0, 64'hA1);
        expect_val("r2_kept", 0, 1, 1'b0, 64'hA2);
        cycle();
        rd_addr0 = {5'd4, 5'd4};
        expect_val("r4_flushed", 0, 0, 1'b1, 64'h0);
        expect_val("r4_kept", 0, 1, 1'b0, 64'hA4);
        cycle();

        mark_en0 = 1'b1; mark_addr0 = 5'd31; cycle();
        rd_addr0 = {5'd31, 5'd31};
        expect_val("zero_never_busy", 0, 0, 1'b1, 64'h0);
        cycle();

        // Swept instance: address 30 is beyond DEPTH, register 0 is the zero register.
        wr_en1 = 1'b1; wr_addr1 = 5'd30; wr_data1 = 32'hBAD0; mark_en1 = 1'b1;
        mark_addr1 = 5'd30; rd_addr1 = {5'd30, 5'd30, 5'd30};
        expect_val("oor_bypass", 1, 0, 1'b0, 64'h0);
        expect_val("oor_busy_wr", 1, 1, 1'b1, 64'h0);
        cycle();
        expect_val("oor_stored", 1, 2, 1'b0, 64'h0);
        expect_val("oor_busy_mark", 1, 0, 1'b1, 64'h0);
        cycle();
        wr_en1 = 1'b1; wr_addr1 = 5'd1;  wr_data1 = 32'h111;  cycle();
        wr_en1 = 1'b1; wr_addr1 = 5'd2;  wr_data1 = 32'h222;  cycle();
        wr_en1 = 1'b1; wr_addr1 = 5'd23; wr_data1 = 32'h2323; cycle();
        wr_en1 = 1'b1; wr_addr1 = 5'd0;  wr_data1 = 32'h5555; cycle();
        rd_addr1 = {5'd23, 5'd2, 5'd1};
        expect_val("sw_p0_r1", 1, 0, 1'b0, 64'h111);
        expect_val("sw_p1_r2", 1, 1, 1'b0, 64'h222);
        expect_val("sw_p2_r23", 1, 2, 1'b0, 64'h2323);
        cycle();
        rd_addr1 = {5'd0, 5'd0, 5'd23};
        expect_val("sw_r23_p0", 1, 0, 1'b0, 64'h2323);
        expect_val("sw_zero_p2", 1, 2, 1'b0, 64'h0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file for the pipelined CPU datapath: `NREAD` combinational read ports, one clocked write port, and a hardwired-zero register. Same-cycle write-to-read bypass lets decode read a value being written back in the same cycle. An integrated per-register busy scoreboard tracks in-flight producers so hazard logic can stall on reads of registers with pending writes. It sits between decode (reads, mark) and writeback (write), replacing the fixed 32×64, 2-read register file.

## Interface
Parameters:
- `WIDTH`, 64, data width in bits
- `DEPTH`, 32, number of registers (≥2)
- `ADDR_W`, `$clog2(DEPTH)`, address width (derived; not overridden)
- `NREAD`, 2, number of read ports (1–4)
- `ZERO_REG`, `DEPTH-1`, index of the hardwired-zero register

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  write enable
- `wr_addr`  in  `ADDR_W`  write register index
- `wr_data`  in  `WIDTH`  write data
- `rd_addr`  in  `NREAD*ADDR_W`  read indices; port k uses bits [k*ADDR_W +: ADDR_W]
- `rd_data`  out  `NREAD*WIDTH`  read data; port k uses bits [k*WIDTH +: WIDTH]
- `rd_busy`  out  `NREAD`  port k's register has a pending producer
- `mark_en`  in  1  set busy for `mark_addr` (instruction issued with a destination)
- `mark_addr`  in  `ADDR_W`  destination being marked
- `flush`  in  1  clear all busy bits (pipeline flush)

## Operation
- Storage: `DEPTH` registers of `WIDTH` bits, plus `DEPTH` busy bits.
- Write: at a rising edge with `wr_en`=1, store `wr_data` at `wr_addr`. The write is ignored if `wr_addr`==`ZERO_REG` or `wr_addr`≥`DEPTH`.
- Read (combinational, per port k, priority order):
  1. `rd_addr_k`==`ZERO_REG` or ≥`DEPTH` → 0.
  2. `wr_en` && `wr_addr`==`rd_addr_k` → `wr_data` (bypass).
  3. Otherwise → stored value.
- Busy update at a rising edge, per register r, priority order:
  1. `flush` → 0.
  2. `mark_en` && `mark_addr`==r → 1.
  3. `wr_en` && `wr_addr`==r → 0.
  4. Otherwise hold.
- Mark and write to the same r in one cycle leaves busy=1, because the new producer supersedes the retiring one.
- `mark_addr`==`ZERO_REG` or ≥`DEPTH` is ignored; `busy[ZERO_REG]` is always 0.
- `rd_busy_k` = `busy[rd_addr_k]` && !(`wr_en` && `wr_addr`==`rd_addr_k`). A retiring write unblocks a reader in the same cycle, consistent with the bypass.
- `rd_busy_k` is 0 for `ZERO_REG` and out-of-range addresses.
- Multiple read ports may address the same register; all return identical data and busy.

## Timing
- Reset: `reset_n` low immediately clears all registers and busy bits, independent of `clk`. While in reset, `rd_data`=0 and `rd_busy`=0 on every port. Writes, marks and flushes are ignored until the first rising edge after `reset_n` rises.
- Write latency: 0 cycles to read ports via bypass; data is stored at edge N and held from N onward.
- Mark latency: `rd_busy` asserts in the cycle after the `mark_en` edge.
- Clear latency: 0 cycles combinationally via the write term; stored busy clears at the write edge.
- Flush: takes effect at the edge; register contents are unaffected.
- Reset asserted mid-cycle together with a write: the reset wins and the write is lost.
- No combinational path from `mark_*` or `flush` to any output.
- Combinational paths exist from `wr_*` and `rd_addr` to `rd_data` and `rd_busy`.

## Test plan
- Reset/zero: write 0xDEAD to r3 → reads return 0xDEAD. Pulse `reset_n` low mid-cycle → r3 reads 0 immediately. Write 0x1234 to `ZERO_REG` → it reads 0.
- Bypass: stored r5=0x11; in one cycle `wr_en`, r5←0x22 with port 0 and port 1 both reading r5 → both show 0x22 that cycle; next cycle with no write they show 0x22 from storage.
- Scoreboard: mark r7 → next cycle `rd_busy`[0]=1 for r7. Write r7 with 0x7 → `rd_busy`[0]=0 in the same cycle and `rd_data`=0x7.
- Simultaneous mark and write on r9 → r9 busy stays 1 the following cycle and holds the written data. Mark r9 plus flush in one cycle → busy 0.
- Flush: mark r1, r2, r4 → all busy; `flush` → all busy 0 next cycle, and contents of r1/r2/r4 are unchanged.
- Parameter sweep: `WIDTH`=32, `DEPTH`=24, `NREAD`=3, `ZERO_REG`=0. Read addr 30 → 0 and not busy; writes and marks to 30 are ignored. All three ports reading distinct registers return the correct values.
